// File: rtl/handshake_dispatch.sv
// handshake_dispatch: queues one-hot channel selects taken from a 4-phase upstream
// handshake and replays them, in arrival order, as 4-phase handshakes on N channels.
// Optional feature macro SEL_CHECK_EN: reject zero/multi-hot selects and raise err_sel.
module handshake_dispatch #(
    parameter int output_size = 8,
    parameter int fifo_depth  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_in,
    input  logic [output_size-1:0]          sel_in,
    output logic                            ack_in,
    output logic [output_size-1:0]          req_out,
    input  logic [output_size-1:0]          ack_out,
    output logic [$clog2(fifo_depth+1)-1:0] fifo_count,
    output logic                            err_sel
);
    localparam int CW = $clog2(fifo_depth + 1);
    localparam int PW = $clog2(fifo_depth);
    localparam logic [CW-1:0] FULL_LVL = CW'(fifo_depth);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [output_size-1:0] SEL_ZERO = {output_size{1'b0}};

    typedef enum logic [0:0] {U_IDLE = 1'b0, U_ACK = 1'b1} u_state_t;
    typedef enum logic [1:0] {D_IDLE = 2'b00, D_REQ = 2'b01, D_RTZ = 2'b10} d_state_t;

    u_state_t               u_state_r, u_state_s;
    d_state_t               d_state_r, d_state_s;
    logic [output_size-1:0] mem_r [fifo_depth];
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          count_r, count_s;
    logic [output_size-1:0] cur_sel_r, cur_sel_s;
    logic [output_size-1:0] req_out_r, req_out_s;
    logic                   ack_in_r;
    logic                   full_s, empty_s, push_try_s, sel_ok_s, push_s, pop_s, hit_s;
    logic [output_size-1:0] head_s;

    assign full_s  = (count_r == FULL_LVL);
    assign empty_s = (count_r == CNT_ZERO);
    assign head_s  = mem_r[rd_ptr_r];
    assign hit_s   = |(ack_out & cur_sel_r);
    assign push_s  = push_try_s & sel_ok_s;

`ifdef SEL_CHECK_EN
    function automatic logic is_one_hot(input logic [output_size-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < output_size; i++) begin
            multi = multi | (v[i] & seen);
            seen  = seen | v[i];
        end
        return seen & ~multi;
    endfunction

    logic err_sel_r;
    assign sel_ok_s = is_one_hot(sel_in);
    assign err_sel  = err_sel_r;

    // Sticky flag: a rejected select keeps err_sel high until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_r <= 1'b0;
        end else begin
            err_sel_r <= err_sel_r | (push_try_s & ~sel_ok_s);
        end
    end
`else
    assign sel_ok_s = 1'b1;
    assign err_sel  = 1'b0;
`endif

    // Upstream handshake: accept while not full (pre-pop count), release on req_in low.
    always_comb begin
        u_state_s  = u_state_r;
        push_try_s = 1'b0;
        case (u_state_r)
            U_IDLE: begin
                if (req_in && !full_s) begin
                    push_try_s = 1'b1;
                    u_state_s  = U_ACK;
                end else begin
                    u_state_s = U_IDLE;
                end
            end
            U_ACK: begin
                if (!req_in) begin
                    u_state_s = U_IDLE;
                end else begin
                    u_state_s = U_ACK;
                end
            end
            default: u_state_s = U_IDLE;
        endcase
    end

    // Downstream replay: pop head, hold request until selected ack, then wait for ack low.
    always_comb begin
        d_state_s = d_state_r;
        cur_sel_s = cur_sel_r;
        req_out_s = SEL_ZERO;
        pop_s     = 1'b0;
        case (d_state_r)
            D_IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    cur_sel_s = head_s;
                    req_out_s = head_s;
                    // a zero entry is dropped without a request pulse
                    if (head_s != SEL_ZERO) begin
                        d_state_s = D_REQ;
                    end else begin
                        d_state_s = D_IDLE;
                    end
                end else begin
                    d_state_s = D_IDLE;
                end
            end
            D_REQ: begin
                if (hit_s) begin
                    d_state_s = D_RTZ;
                end else begin
                    req_out_s = cur_sel_r;
                    d_state_s = D_REQ;
                end
            end
            D_RTZ: begin
                if (!hit_s) begin
                    d_state_s = D_IDLE;
                end else begin
                    d_state_s = D_RTZ;
                end
            end
            default: d_state_s = D_IDLE;
        endcase
    end

    // Occupancy update covering push-only, pop-only and simultaneous push/pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_state_r <= U_IDLE;
            d_state_r <= D_IDLE;
            cur_sel_r <= SEL_ZERO;
            req_out_r <= SEL_ZERO;
            ack_in_r  <= 1'b0;
            count_r   <= CNT_ZERO;
        end else begin
            u_state_r <= u_state_s;
            d_state_r <= d_state_s;
            cur_sel_r <= cur_sel_s;
            req_out_r <= req_out_s;
            ack_in_r  <= (u_state_s == U_ACK);
            count_r   <= count_s;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= SEL_ZERO;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sel_in;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign ack_in     = ack_in_r;
    assign req_out    = req_out_r;
    assign fifo_count = count_r;

endmodule
